apb_bus_arbiter: RTL
====================

Name: apb_bus_arbiter

Overview:
- Two-requester arbiter that shares the single CPU-side APB master port between the RV32I core and a second bus master (DMA engine).
- Sits between the requesters and APB_Master. Selects one requester, forwards its transfer, waits for completion, then returns data, ready and error to that requester only.
- Round-robin fairness plus a per-transfer timeout so a stalled peripheral cannot hang the bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles from issue to downstream ready before forced error completion; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transfer.

Ports:
- clk  in  1  system clock (PCLK domain).
- reset  in  1  asynchronous, active-low reset.
- cpu_transfer  in  1  CPU request level; cpu_write/cpu_addr/cpu_wdata stable while high.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid when cpu_ready=1, held until next CPU completion.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  timeout flag, valid with cpu_ready.
- dma_transfer, dma_write, dma_addr, dma_wdata, dma_rdata, dma_ready, dma_err: same widths and meaning for the DMA requester.
- transfer  out  1  one-cycle start pulse to APB_Master.
- write  out  1  to APB_Master.
- addr  out  32  to APB_Master.
- wdata  out  32  to APB_Master.
- rdata  in  32  from APB_Master.
- ready  in  1  completion from APB_Master.
- grant  out  1  owner of the current or last transfer: 0 = CPU, 1 = DMA.
- busy  out  1  high in ISSUE, WAIT and DONE.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE, rr_ptr = 0 (CPU favoured), timeout counter = 0.
  - All outputs 0, including the held rdata registers and grant.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If exactly one *_transfer is high, grant it.
  - If both are high, grant the requester named by rr_ptr.
  - On grant: register write/addr/wdata from the winner, set grant, toggle rr_ptr to the other requester, go to ISSUE.
  - If neither is high, stay in IDLE.
- ISSUE:
  - transfer=1 for exactly this cycle, using the registered write/addr/wdata.
  - Counter loads 1.
  - If ready=1, capture rdata and go to DONE; otherwise go to WAIT.
- WAIT:
  - transfer=0. write/addr/wdata stay constant until DONE.
  - Counter increments each cycle.
  - If ready=1, capture rdata, err=0, go to DONE.
  - Else if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES, set captured data = ERR_RDATA, err=1, go to DONE.
  - ready takes priority over timeout in the same cycle.
- DONE (one cycle):
  - Granted requester's *_ready=1, *_err per capture, and its *_rdata register updated.
  - The other requester's outputs are untouched.
  - Next state is IDLE.
- Requester rules:
  - A requester drops *_transfer on the edge after its *_ready. IDLE then samples fresh levels.
  - Re-asserting *_transfer on that edge is a new transaction and competes normally.
- Latency: zero-wait completion (ready in cycle n after the transfer pulse) gives *_ready in cycle n+1. Minimum request-to-ready is 3 cycles.
- Fairness: under continuous requests from both, grants strictly alternate CPU, DMA, CPU, ... A request is never starved for more than one transfer.
- Ignored inputs: downstream ready is ignored in IDLE and DONE, so a late ready after a timeout is discarded. Requests arriving during ISSUE/WAIT/DONE are held by the requester and are not lost.
- Reset mid-transfer: everything returns to its reset value immediately. APB_Master shares the same reset, so no orphan transfer remains.
- Counter width: clog2(TIMEOUT_CYCLES+1); it never wraps before the compare.

Test Plan:
- CPU-only write: cpu_transfer=1, addr=32'h1000_2000, wdata=32'h0000_00A5; downstream ready 2 cycles after the transfer pulse → exactly one transfer pulse with those values, cpu_ready 1 cycle later, cpu_err=0, dma_ready stays 0.
- DMA-only read: dma read of 32'h1000_0004, rdata=32'h1234_5678 returned with ready → dma_rdata=32'h1234_5678, dma_ready pulse, grant=1, cpu_rdata unchanged.
- Simultaneous requests after reset: both held high for 4 transactions → grant order CPU, DMA, CPU, DMA. Each transfer pulse carries the matching requester's addr.
- Timeout with TIMEOUT_CYCLES=8: ready never asserted → cpu_ready with cpu_err=1 and cpu_rdata=32'hDEAD_BEEF. A ready injected 2 cycles later is ignored, and no spurious ready appears on either port.
- Reset mid-WAIT: reset=0 while in WAIT → busy, transfer, cpu_ready/dma_ready and grant all 0 immediately. After release the next CPU request is granted first (rr_ptr=0).
- Ready coincident with timeout: ready=1 in the cycle the counter hits TIMEOUT_CYCLES → normal completion, err=0, real rdata returned.

Source files
------------

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter
//   Shares one APB master port between the CPU core and the DMA engine.
//   A requester is selected (round-robin when both ask), its transfer is
//   forwarded as a one-cycle start pulse, and the completion is returned
//   to that requester only. A per-transfer timeout forces an error
//   completion so a stalled peripheral cannot hang the bus.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   cpu_transfer/write/addr/wdata   CPU request (level, held until cpu_ready)
//   cpu_rdata/ready/err         CPU completion (ready is a 1-cycle pulse,
//                               rdata/err held until the next CPU completion)
//   dma_*                       same for the DMA requester
//   transfer/write/addr/wdata   request to APB_Master (transfer = start pulse)
//   rdata/ready                 completion from APB_Master
//   grant                       owner of current/last transfer (0 CPU, 1 DMA)
//   busy                        high while a transfer is in flight
module apb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_transfer,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  input  logic        dma_transfer,
  input  logic        dma_write,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        dma_err,
  output logic        transfer,
  output logic        write,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready,
  output logic        grant,
  output logic        busy
);

  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt;

  // Completion decision for the in-flight transfer.
  logic        finish;
  logic [31:0] fin_data;
  logic        fin_err;
  logic        pick;

  always_comb begin
    finish   = 1'b0;
    fin_data = rdata;
    fin_err  = 1'b0;
    case (state)
      ST_ISSUE: finish = ready;
      ST_WAIT: begin
        if (ready) begin
          finish = 1'b1;
        end else if (TO_EN && cnt == TO_VAL) begin
          // ready wins over the timeout when both happen in one cycle
          finish   = 1'b1;
          fin_data = ERR_RDATA;
          fin_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Winner in IDLE: the single requester, or rr_ptr when both ask.
  always_comb begin
    if (cpu_transfer && dma_transfer) pick = rr_ptr;
    else                              pick = dma_transfer;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= 1'b0;
      cnt       <= '0;
      transfer  <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      grant     <= 1'b0;
      busy      <= 1'b0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      dma_rdata <= '0;
      dma_ready <= 1'b0;
      dma_err   <= 1'b0;
    end else begin
      transfer  <= 1'b0;
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_transfer || dma_transfer) begin
            grant    <= pick;
            rr_ptr   <= ~pick;
            write    <= pick ? dma_write : cpu_write;
            addr     <= pick ? dma_addr  : cpu_addr;
            wdata    <= pick ? dma_wdata : cpu_wdata;
            transfer <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (state == ST_ISSUE) cnt <= CNT_W'(1);
          else                   cnt <= cnt + 1'b1;
          if (finish) begin
            // Results go straight into the owner's held output registers,
            // so they are visible during the DONE cycle with the ready pulse.
            if (grant) begin
              dma_rdata <= fin_data;
              dma_err   <= fin_err;
              dma_ready <= 1'b1;
            end else begin
              cpu_rdata <= fin_data;
              cpu_err   <= fin_err;
              cpu_ready <= 1'b1;
            end
            state <= ST_DONE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
